regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register file write port (WE3/A3/WD3) between two writeback requesters: port 0 (ALU) and port 1 (load/store unit).
- Each requester has a valid/ready handshake into a one-entry holding buffer.
- The arbiter drains one buffer per clock into the register file, oldest first, and round-robin on ties.
- Exports a 32-bit pending-write mask so the decode stage can stall on read-after-write hazards.

Parameters:
- AW, 5, register address width (32 architectural registers).
- DW, 32, write data width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- CLR  in  1  reset: one clock; synchronous, active-high.
- V0  in  1  port 0 write request valid.
- A0  in  AW  port 0 destination register.
- D0  in  DW  port 0 write data.
- R0  out  1  port 0 ready.
- V1  in  1  port 1 write request valid.
- A1W  in  AW  port 1 destination register.
- D1  in  DW  port 1 write data.
- R1  out  1  port 1 ready.
- WE3  out  1  register file write enable.
- A3  out  AW  register file write address.
- WD3  out  DW  register file write data.
- PEND  out  2**AW  bit i=1 while a buffered write to register i is not yet committed; bit 0 always 0.
- GNT  out  2  one-hot: buffer being drained this cycle (GNT[0]=port 0).

Behaviour:
- State:
  - Per port: full bit, address register, data register.
  - One age bit OLD (which full buffer was loaded first).
  - One round-robin pointer RR (port to favour on a tie).
- Reset (CLR high at posedge):
  - Both buffers become empty; OLD=0; RR=0.
  - Any held write is discarded and never reaches the register file.
- While CLR is high:
  - R0=R1=0 and WE3=0 combinationally.
  - No handshake completes.
- After reset: WE3=0, A3=0, WD3=0, PEND=0, GNT=0, R0=R1=1.
- Handshake:
  - A transfer occurs on port k at a posedge when Vk and Rk are both high.
  - Data and address are captured into buffer k.
  - Rk = (buffer k empty) OR (buffer k granted this cycle). A full buffer being drained accepts a new entry in the same cycle.
  - Requester must hold Vk, address and data stable until Rk is seen high.
- Grant (combinational from buffer state):
  - Neither buffer full: GNT=00, WE3=0.
  - One buffer full: that buffer is granted.
  - Both full, loaded on different cycles: the older (per OLD) is granted. This preserves program order for same-address writes.
  - Both full, loaded on the same cycle: port RR is granted.
- Write port:
  - WE3=1 whenever GNT≠0. A3 and WD3 come from the granted buffer.
  - When GNT=0, A3 and WD3 are 0.
  - The register file commits at the same posedge the buffer drains.
  - Latency: accepted at edge N, committed at edge N+1 at best. Worst case is N+2 (one competing older entry).
- Writes to register 0:
  - Accepted and buffered normally, and granted in turn.
  - WE3 is forced 0 for that cycle; PEND bit 0 never sets.
- RR update: on every cycle with a grant, RR := the port not granted.
- OLD update:
  - When exactly one buffer is full after the edge, OLD points to it.
  - When a new entry loads while the other buffer remains full, OLD points to the remaining one.
- PEND:
  - Computed from the buffer state after the posedge of acceptance. It is high from the cycle after acceptance through the cycle of commit, and clears after the commit edge.
  - If both buffers target the same register, the bit stays set until both commit.
- Throughput:
  - One commit per cycle.
  - With both ports streaming continuously, grants alternate 0,1,0,1.

Test Plan:
- Reset with CLR=1 for 2 cycles, V0=1 held → R0=0, WE3=0 throughout. After release: R0=R1=1, PEND=0.
- Single write: port 0 writes A0=1, D0=0x0ABCDEF0 → next cycle WE3=1, A3=1, WD3=0x0ABCDEF0, PEND[1]=1. Following cycle PEND=0 and register file RD1 (A1=1) returns 0x0ABCDEF0.
- Same-cycle collision: port 0 writes (4, 0x11111111) and port 1 writes (4, 0xFFFFFFFF) with RR=0 → port 0 commits first, port 1 next. Final r4=0xFFFFFFFF; PEND[4] high for 2 cycles.
- Age ordering: port 1 buffers (5, 0x5) while port 0 holds an older entry (6, 0x6) → port 0 commits first, then port 1. A new port 0 request during the drain is accepted via the R0 drain-and-refill path.
- Register 0: port 1 writes (0, 0xDEADBEEF) → GNT=10 for one cycle, WE3=0, PEND stays 0, r0 reads 0.
- Reset mid-operation: both buffers full, CLR=1 for one edge → neither entry is committed, PEND=0 next cycle. Streaming 8 writes on both ports afterwards gives alternating GNT with zero idle cycles.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port writeback arbiter sharing one register file write port
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               V0,
    input  logic [AW-1:0]      A0,
    input  logic [DW-1:0]      D0,
    output logic               R0,
    input  logic               V1,
    input  logic [AW-1:0]      A1W,
    input  logic [DW-1:0]      D1,
    output logic               R1,
    output logic               WE3,
    output logic [AW-1:0]      A3,
    output logic [DW-1:0]      WD3,
    output logic [2**AW-1:0]   PEND,
    output logic [1:0]         GNT
);

    logic          full0, full1;
    logic [AW-1:0] a0r, a1r;
    logic [DW-1:0] d0r, d1r;
    logic          old;
    logic          rr;
    logic          tie;

    logic          acc0, acc1;
    logic          nf0, nf1;

    // tie marks two entries loaded on the same edge, where age cannot decide
    always_comb begin
        GNT = 2'b00;
        if (full0 && full1) begin
            GNT = (tie ? rr : old) ? 2'b10 : 2'b01;
        end else if (full0) begin
            GNT = 2'b01;
        end else if (full1) begin
            GNT = 2'b10;
        end
    end

    always_comb begin
        A3  = '0;
        WD3 = '0;
        if (GNT[0]) begin
            A3  = a0r;
            WD3 = d0r;
        end else if (GNT[1]) begin
            A3  = a1r;
            WD3 = d1r;
        end
    end

    assign WE3 = !CLR && (GNT != 2'b00) && (A3 != '0);
    assign R0  = !CLR && (!full0 || GNT[0]);
    assign R1  = !CLR && (!full1 || GNT[1]);

    assign acc0 = V0 && R0;
    assign acc1 = V1 && R1;
    assign nf0  = acc0 || (full0 && !GNT[0]);
    assign nf1  = acc1 || (full1 && !GNT[1]);

    always_comb begin
        PEND = '0;
        for (int i = 1; i < 2**AW; i++) begin
            PEND[i] = (full0 && (a0r == AW'(i))) || (full1 && (a1r == AW'(i)));
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            full0 <= 1'b0;
            full1 <= 1'b0;
            a0r   <= '0;
            a1r   <= '0;
            d0r   <= '0;
            d1r   <= '0;
            old   <= 1'b0;
            rr    <= 1'b0;
            tie   <= 1'b0;
        end else begin
            full0 <= nf0;
            full1 <= nf1;
            if (acc0) begin
                a0r <= A0;
                d0r <= D0;
            end
            if (acc1) begin
                a1r <= A1W;
                d1r <= D1;
            end
            // favour the port that lost this cycle
            if (GNT != 2'b00) begin
                rr <= GNT[0];
            end
            if (nf0 && nf1) begin
                if (acc0 && acc1) begin
                    tie <= 1'b1;
                end else if (acc0) begin
                    old <= 1'b1;
                    tie <= 1'b0;
                end else if (acc1) begin
                    old <= 1'b0;
                    tie <= 1'b0;
                end
            end else if (nf0) begin
                old <= 1'b0;
                tie <= 1'b0;
            end else if (nf1) begin
                old <= 1'b1;
                tie <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        V0, V1;
    logic [4:0]  A0, A1W;
    logic [31:0] D0, D1;
    logic        R0, R1, WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] PEND;
    logic [1:0]  GNT;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
        .CLK(CLK), .CLR(CLR),
        .V0(V0), .A0(A0), .D0(D0), .R0(R0),
        .V1(V1), .A1W(A1W), .D1(D1), .R1(R1),
        .WE3(WE3), .A3(A3), .WD3(WD3), .PEND(PEND), .GNT(GNT)
    );

    always #5 CLK = ~CLK;

    // reference: each port holds at most one entry stamped with its load cycle
    bit          mf[2];
    logic [4:0]  ma[2];
    logic [31:0] md[2];
    int          mts[2];
    int          mrr;
    int          cyc;
    logic [31:0] mrf[32];
    logic [31:0] drf[32];
    bit          acc0, acc1;
    logic [1:0]  last_gnt;
    logic        last_we;
    logic [31:0] last_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int          g;
        logic        er0, er1, ewe;
        logic [4:0]  ea3;
        logic [31:0] ewd, epend;
        logic [1:0]  egnt;
        #1;
        g = -1;
        if (mf[0] && mf[1]) begin
            if (mts[0] < mts[1])      g = 0;
            else if (mts[1] < mts[0]) g = 1;
            else                      g = mrr;
        end else if (mf[0]) g = 0;
        else if (mf[1])     g = 1;
        egnt  = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
        ea3   = (g < 0) ? 5'd0 : ma[g];
        ewd   = (g < 0) ? 32'd0 : md[g];
        ewe   = !CLR && (g >= 0) && (ea3 != 5'd0);
        er0   = !CLR && (!mf[0] || g == 0);
        er1   = !CLR && (!mf[1] || g == 1);
        epend = 32'd0;
        for (int k = 0; k < 2; k++) begin
            if (mf[k] && ma[k] != 5'd0) epend[ma[k]] = 1'b1;
        end
        chk("gnt", {30'd0, GNT}, {30'd0, egnt});
        chk("we3", {31'd0, WE3}, {31'd0, ewe});
        chk("a3", {27'd0, A3}, {27'd0, ea3});
        chk("wd3", WD3, ewd);
        chk("r0", {31'd0, R0}, {31'd0, er0});
        chk("r1", {31'd0, R1}, {31'd0, er1});
        chk("pend", PEND, epend);
        last_gnt  = GNT;
        last_we   = WE3;
        last_pend = PEND;
        if (WE3 === 1'b1) drf[A3] = WD3;
        acc0 = er0 && V0;
        acc1 = er1 && V1;
        @(posedge CLK);
        if (CLR) begin
            mf[0] = 1'b0;
            mf[1] = 1'b0;
            mrr   = 0;
        end else begin
            if (g >= 0) begin
                mf[g] = 1'b0;
                mrr   = 1 - g;
                if (ewe) mrf[ma[g]] = md[g];
            end
            if (acc0) begin mf[0] = 1'b1; ma[0] = A0;  md[0] = D0; mts[0] = cyc; end
            if (acc1) begin mf[1] = 1'b1; ma[1] = A1W; md[1] = D1; mts[1] = cyc; end
        end
        cyc++;
        @(negedge CLK);
    endtask

    // requester side: hold the request until it was accepted, then pick a new one
    task automatic drive_next(input int vpct, input int amask);
        if (acc0 || !V0) begin
            V0 = ($urandom_range(99) < vpct);
            A0 = 5'($urandom) & 5'(amask);
            D0 = $urandom;
        end
        if (acc1 || !V1) begin
            V1 = ($urandom_range(99) < vpct);
            A1W = 5'($urandom) & 5'(amask);
            D1 = $urandom;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mrf[i] = 32'd0;
            drf[i] = 32'd0;
        end
        mf[0] = 1'b0; mf[1] = 1'b0;
        mts[0] = 0;   mts[1] = 0;
        ma[0] = 5'd0; ma[1] = 5'd0;
        md[0] = 32'd0; md[1] = 32'd0;
        mrr = 0; cyc = 0;
        CLR = 1'b1; V0 = 1'b1; A0 = 5'd3; D0 = 32'h33; V1 = 1'b0; A1W = 5'd0; D1 = 32'd0;
        @(posedge CLK);
        @(negedge CLK);

        // reset held two cycles with a pending request
        step();
        step();
        CLR = 1'b0; V0 = 1'b0;
        step();
        chk("post_reset_pend", last_pend, 32'd0);

        // single write
        V0 = 1'b1; A0 = 5'd1; D0 = 32'h0ABCDEF0;
        step();
        V0 = 1'b0;
        step();
        chk("single_we", {31'd0, last_we}, 32'd1);
        chk("single_pend", last_pend, 32'h2);
        step();
        chk("single_pend_clr", last_pend, 32'd0);
        chk("single_rf", drf[1], 32'h0ABCDEF0);

        // register 0 write: granted, never committed
        V1 = 1'b1; A1W = 5'd0; D1 = 32'hDEADBEEF;
        step();
        V1 = 1'b0;
        step();
        chk("r0w_gnt", {30'd0, last_gnt}, 32'd2);
        chk("r0w_we", {31'd0, last_we}, 32'd0);
        chk("r0w_pend", last_pend, 32'd0);

        // same-cycle collision on register 4
        V0 = 1'b1; A0 = 5'd4; D0 = 32'h11111111;
        V1 = 1'b1; A1W = 5'd4; D1 = 32'hFFFFFFFF;
        step();
        V0 = 1'b0; V1 = 1'b0;
        step();
        chk("coll_gnt_a", {30'd0, last_gnt}, 32'd1);
        chk("coll_pend_a", last_pend, 32'h10);
        step();
        chk("coll_gnt_b", {30'd0, last_gnt}, 32'd2);
        chk("coll_pend_b", last_pend, 32'h10);
        step();
        chk("coll_pend_clr", last_pend, 32'd0);
        chk("coll_rf", drf[4], 32'hFFFFFFFF);

        // age ordering with a drain-and-refill on port 0
        V0 = 1'b1; A0 = 5'd6; D0 = 32'h6;
        step();
        V0 = 1'b1; A0 = 5'd7; D0 = 32'h7;
        V1 = 1'b1; A1W = 5'd5; D1 = 32'h5;
        step();
        chk("age_refill", {31'd0, acc0}, 32'd1);
        V0 = 1'b0; V1 = 1'b0;
        step(); step(); step();

        // reset with both buffers full
        V0 = 1'b1; A0 = 5'd8; D0 = 32'h88;
        V1 = 1'b1; A1W = 5'd9; D1 = 32'h99;
        step();
        V0 = 1'b0; V1 = 1'b0; CLR = 1'b1;
        step();
        CLR = 1'b0;
        step();
        chk("midrst_pend", last_pend, 32'd0);
        chk("midrst_we", {31'd0, last_we}, 32'd0);

        // streaming on both ports: grants alternate with no idle cycle
        V0 = 1'b1; A0 = 5'd10; D0 = $urandom;
        V1 = 1'b1; A1W = 5'd20; D1 = $urandom;
        for (int i = 0; i < 17; i++) begin
            step();
            if (i >= 1) chk("stream_gnt", {30'd0, last_gnt}, (i % 2 == 1) ? 32'd1 : 32'd2);
            drive_next(100, 31);
        end
        V0 = 1'b0; V1 = 1'b0;
        step(); step(); step();

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            CLR = ($urandom_range(59) == 0);
            step();
            if (CLR) begin
                V0 = 1'b0; V1 = 1'b0;
            end
            drive_next(60, 7);
        end
        CLR = 1'b0; V0 = 1'b0; V1 = 1'b0;
        step(); step(); step();

        for (int i = 0; i < 32; i++) chk("rf_final", drf[i], mrf[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
